// File: rtl/periph_bus_arbiter_pkg.sv
// Shared definitions for the peripheral bus arbiter: FSM encoding, default
// peripheral window and the window decode helper.
package periph_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [31:0] PERIPH_BASE  = 32'h0000_7f00;
    localparam logic [31:0] PERIPH_LIMIT = 32'h0000_7fff;

    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/periph_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// and on contention the master named by i_ptr wins.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic       o_valid,
    output logic       o_winner
);

    // NOTE: every output is assigned on every path through always_comb, so no latch is inferred.
    always_comb begin
        o_valid  = |i_req;
        o_winner = (i_req == 2'b11) ? i_ptr : i_req[1];
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the memory-mapped peripheral port; one
// single-word transaction per three cycles, out-of-window accesses are blocked.
module periph_bus_arbiter
    import periph_bus_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE  = PERIPH_BASE,
    parameter logic [31:0] LIMIT = PERIPH_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_byteen,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_byteen,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic [31:0] p_addr,
    output logic [3:0]  p_byteen,
    output logic [31:0] p_din,
    input  logic [31:0] p_dout
);

    state_t      r_state;
    logic        r_ptr;
    logic        r_winner;
    logic        r_err;

    logic        w_valid;
    logic        w_winner;
    logic [31:0] w_addr;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata;
    logic        w_in_window;

    rr_pick2 u_pick (
        .i_req    ({m1_req, m0_req}),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    always_comb begin
        w_addr      = w_winner ? m1_addr   : m0_addr;
        w_byteen    = w_winner ? m1_byteen : m0_byteen;
        w_wdata     = w_winner ? m1_wdata  : m0_wdata;
        w_in_window = in_window(w_addr, BASE, LIMIT);
    end

    // The p_* registers double as the latched payload; they are only loaded for
    // in-window requests, so a blocked access keeps the peripheral port at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= 1'b0;
            r_winner <= 1'b0;
            r_err    <= 1'b0;
            p_addr   <= '0;
            p_byteen <= '0;
            p_din    <= '0;
            m0_ack   <= 1'b0;
            m0_rdata <= '0;
            m0_err   <= 1'b0;
            m1_ack   <= 1'b0;
            m1_rdata <= '0;
            m1_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults first make every output a one-cycle pulse unless a state re-asserts it.
            p_addr   <= '0;
            p_byteen <= '0;
            p_din    <= '0;
            m0_ack   <= 1'b0;
            m0_rdata <= '0;
            m0_err   <= 1'b0;
            m1_ack   <= 1'b0;
            m1_rdata <= '0;
            m1_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_winner <= w_winner;
                        r_err    <= ~w_in_window;
                        if (w_in_window) begin
                            p_addr   <= w_addr;
                            p_byteen <= w_byteen;
                            p_din    <= w_wdata;
                        end
                        r_state <= S_ACCESS;
                    end
                end

                // Blocked requests still spend this slot so every master sees a
                // uniform two-cycle ack latency.
                S_ACCESS: begin
                    if (r_winner) begin
                        m1_ack   <= 1'b1;
                        m1_rdata <= r_err ? '0 : p_dout;
                        m1_err   <= r_err;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_rdata <= r_err ? '0 : p_dout;
                        m0_err   <= r_err;
                    end
                    r_state <= S_RESP;
                end

                S_RESP: begin
                    r_ptr   <= ~r_winner;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a transaction-level schedule model and a word memory.
module tb_periph_bus_arbiter;

    localparam logic [31:0] WIN_LO = 32'h0000_7f00;
    localparam logic [31:0] WIN_HI = 32'h0000_7fff;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] p_addr, p_din, p_dout;
    logic [3:0]  p_byteen;

    logic [31:0] tube      [64] = '{default: 32'h0};
    logic [31:0] model_mem [64] = '{default: 32'h0};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Transaction schedule model: one outstanding grant, acked two cycles later.
    bit          pend, pw, pin, ptr_m;
    int          pg, next_free;
    logic [31:0] pa, pd, prd;
    logic [3:0]  pb;
    bit          retired, retired_who;
    logic [31:0] last_rdata;
    logic        last_err;
    int          ack_cyc [$];
    bit          ack_who [$];

    periph_bus_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_byteen (m0_byteen),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_byteen (m1_byteen),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .p_addr    (p_addr),
        .p_byteen  (p_byteen),
        .p_din     (p_din),
        .p_dout    (p_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // Attached tube/peripheral: combinational read, byte-strobed write on the edge.
    assign p_dout = tube[p_addr[7:2]];
    always @(posedge clk)
        if (p_byteen != 4'h0) tube[p_addr[7:2]] <= merge(tube[p_addr[7:2]], p_din, p_byteen);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(input int m, input logic req, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (m == 0) begin
            m0_req = req; m0_addr = a; m0_byteen = be; m0_wdata = wd;
        end else begin
            m1_req = req; m1_addr = a; m1_byteen = be; m1_wdata = wd;
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model.
    task automatic run_cycle();
        logic [31:0] e_pa, e_pd, e_rd0, e_rd1;
        logic [3:0]  e_pb;
        logic        e_ack0, e_ack1, e_err0, e_err1;
        bit          w;
        e_pa = '0; e_pd = '0; e_pb = '0; e_rd0 = '0; e_rd1 = '0;
        e_ack0 = 1'b0; e_ack1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
        retired = 1'b0;
        @(negedge clk);
        if (pend && cyc == pg + 1 && pin) begin
            e_pa = pa; e_pb = pb; e_pd = pd;
        end
        if (pend && cyc == pg + 2) begin
            if (pw) begin e_ack1 = 1'b1; e_rd1 = pin ? prd : '0; e_err1 = ~pin; end
            else    begin e_ack0 = 1'b1; e_rd0 = pin ? prd : '0; e_err0 = ~pin; end
        end
        check("p_addr",   p_addr,          e_pa);
        check("p_byteen", 32'(p_byteen),   32'(e_pb));
        check("p_din",    p_din,           e_pd);
        check("m0_ack",   32'(m0_ack),     32'(e_ack0));
        check("m1_ack",   32'(m1_ack),     32'(e_ack1));
        check("m0_rdata", m0_rdata,        e_rd0);
        check("m1_rdata", m1_rdata,        e_rd1);
        check("m0_err",   32'(m0_err),     32'(e_err0));
        check("m1_err",   32'(m1_err),     32'(e_err1));
        if (m0_ack) begin ack_cyc.push_back(cyc); ack_who.push_back(1'b0); last_rdata = m0_rdata; last_err = m0_err; end
        if (m1_ack) begin ack_cyc.push_back(cyc); ack_who.push_back(1'b1); last_rdata = m1_rdata; last_err = m1_err; end

        if (pend && cyc == pg + 1 && pin && pb != 4'h0)
            model_mem[pa[7:2]] = merge(model_mem[pa[7:2]], pd, pb);
        if (pend && cyc == pg + 2) begin
            pend = 1'b0; retired = 1'b1; retired_who = pw;
        end
        if (rst_n && !pend && cyc >= next_free && (m0_req || m1_req)) begin
            w    = (m0_req && m1_req) ? ptr_m : m1_req;
            pw   = w;
            pa   = w ? m1_addr : m0_addr;
            pb   = w ? m1_byteen : m0_byteen;
            pd   = w ? m1_wdata : m0_wdata;
            pin  = (pa >= WIN_LO) && (pa <= WIN_HI);
            prd  = model_mem[pa[7:2]];
            pg   = cyc;
            pend = 1'b1;
            ptr_m = ~w;
            next_free = cyc + 3;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        pend = 1'b0; ptr_m = 1'b0; next_free = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        cyc = 0;
        ack_cyc.delete();
        ack_who.delete();
    endtask

    task automatic do_txn(input int m, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
        bit got;
        got = 1'b0;
        drive(m, 1'b1, a, be, wd);
        for (int i = 0; i < 8 && !got; i++) begin
            run_cycle();
            if (retired && retired_who == 1'(m)) got = 1'b1;
        end
        check("txn_done", 32'(got), 32'd1);
        drive(m, 1'b0, '0, '0, '0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] edges [6];
        edges = '{32'h0000_7eff, 32'h0000_7f00, 32'h0000_7fff, 32'h0000_8000,
                  32'h0000_0000, 32'hffff_ffff};
        case ($urandom % 8)
            0:       return $urandom();
            1:       return edges[$urandom_range(0, 5)];
            default: return WIN_LO + {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        endcase
    endfunction

    function automatic logic [3:0] rand_be();
        return ($urandom % 3 == 0) ? 4'h0 : 4'($urandom());
    endfunction

    initial begin
        logic [31:0] edge_addr [5];
        bit          busy;
        edge_addr = '{32'h0000_7eff, 32'h0000_7f00, 32'h0000_7fff, 32'h0000_8000, 32'hffff_ffff};
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        #1;
        hold_reset();
        check("rst_p_byteen", 32'(p_byteen), 32'd0);
        check("rst_p_addr",   p_addr,        32'd0);
        check("rst_acks",     32'({m1_ack, m0_ack}), 32'd0);
        check("rst_rdata",    m0_rdata | m1_rdata,   32'd0);
        release_reset();
        run_cycle();
        run_cycle();

        do_txn(0, 32'h0000_7f50, 4'hF, 32'h1234_5678);
        check("wr_err", 32'(last_err), 32'd0);
        check("tube_g0_write", tube[6'h14], 32'h1234_5678);

        do_txn(1, 32'h0000_7f54, 4'hF, 32'h0000_0008);
        do_txn(1, 32'h0000_7f54, 4'h0, 32'hffff_ffff);
        check("read_rdata", last_rdata, 32'h0000_0008);

        do_txn(0, 32'h0000_1000, 4'hF, 32'hcafe_f00d);
        check("oow_err",   32'(last_err), 32'd1);
        check("oow_rdata", last_rdata,    32'd0);

        do_txn(0, 32'h0000_7f50, 4'b0100, 32'haabb_ccdd);
        check("tube_partial", tube[6'h14], 32'h12bb_5678);

        for (int i = 0; i < 5; i++) begin
            do_txn(i % 2, edge_addr[i], 4'h3, 32'h5a5a_0000 + 32'(i));
            check("edge_err", 32'(last_err),
                  32'((edge_addr[i] < WIN_LO) || (edge_addr[i] > WIN_HI)));
        end

        hold_reset();
        drive(0, 1'b1, 32'h0000_7f04, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h0000_7f08, 4'h0, 32'h0);
        release_reset();
        for (int i = 0; i < 12; i++) run_cycle();
        check("cont_ack_count", 32'(ack_cyc.size()), 32'd4);
        if (ack_cyc.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("cont_ack_cyc", 32'(ack_cyc[i]), 32'(2 + 3 * i));
                check("cont_ack_who", 32'(ack_who[i]), 32'(i % 2));
            end
        end

        hold_reset();
        release_reset();
        drive(1, 1'b1, 32'h0000_7f60, 4'hF, 32'hdead_beef);
        run_cycle();
        check("midrst_pbe_active", 32'(p_byteen), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_pbe_async", 32'(p_byteen), 32'd0);
        check("midrst_p_addr",    p_addr,        32'd0);
        hold_reset();
        check("midrst_no_write", tube[6'h18], model_mem[6'h18]);
        check("midrst_no_ack",   32'({m1_ack, m0_ack}), 32'd0);
        drive(0, 1'b1, 32'h0000_7f0c, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h0000_7f10, 4'h0, 32'h0);
        release_reset();
        for (int i = 0; i < 4; i++) run_cycle();
        check("midrst_ack_count", 32'(ack_cyc.size()), 32'd1);
        if (ack_cyc.size() >= 1) begin
            check("midrst_first_cyc", 32'(ack_cyc[0]), 32'd2);
            check("midrst_first_who", 32'(ack_who[0]), 32'd0);
        end

        for (int n = 0; n < 1500; n++) begin
            run_cycle();
            for (int m = 0; m < 2; m++) begin
                busy = (m == 0) ? m0_req : m1_req;
                if (busy && retired && retired_who == 1'(m)) begin
                    if ($urandom % 2 == 0) drive(m, 1'b1, rand_addr(), rand_be(), $urandom());
                    else                   drive(m, 1'b0, '0, '0, '0);
                end else if (busy && !(pend && pw == 1'(m)) && $urandom % 8 == 0) begin
                    drive(m, 1'b0, '0, '0, '0);
                end else if (!busy && $urandom % 3 == 0) begin
                    drive(m, 1'b1, rand_addr(), rand_be(), $urandom());
                end
            end
        end
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 4; i++) run_cycle();

        for (int i = 0; i < 64; i++) check("tube_final", tube[i], model_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
